// File: rtl/rdptr_empty_ae_if.sv
// rtl/rdptr_empty_ae_if.sv - read-side pointer/flag bundle for an async FIFO
//
// Groups the read-domain handshake and status signals of rdptr_empty_ae.
//   i_rd_en            read request (master -> block)
//   i_wrptr_gray_sync  Gray write pointer, already in the read domain
//   i_uf_clr           clears the sticky underflow flag
//   o_rdptr_gray       registered Gray read pointer for the write domain
//   o_rdaddr           RAM read address
//   o_empty            registered empty flag
//   o_aempty           registered almost-empty flag
//   o_rd_level         registered occupancy seen by the read side
//   o_underflow        sticky read-while-empty flag
// The master modport is the read-side user; the slave modport is the block.
interface rdptr_empty_ae_if #(
   parameter int PTR_WIDTH = 3
);
   logic                 i_rd_en;
   logic [PTR_WIDTH:0]   i_wrptr_gray_sync;
   logic                 i_uf_clr;
   logic [PTR_WIDTH:0]   o_rdptr_gray;
   logic [PTR_WIDTH-1:0] o_rdaddr;
   logic                 o_empty;
   logic                 o_aempty;
   logic [PTR_WIDTH:0]   o_rd_level;
   logic                 o_underflow;

   modport master (
      output i_rd_en,
      output i_wrptr_gray_sync,
      output i_uf_clr,
      input  o_rdptr_gray,
      input  o_rdaddr,
      input  o_empty,
      input  o_aempty,
      input  o_rd_level,
      input  o_underflow
   );

   modport slave (
      input  i_rd_en,
      input  i_wrptr_gray_sync,
      input  i_uf_clr,
      output o_rdptr_gray,
      output o_rdaddr,
      output o_empty,
      output o_aempty,
      output o_rd_level,
      output o_underflow
   );
endinterface

// File: rtl/rdptr_empty_ae.sv
// rtl/rdptr_empty_ae.sv - async FIFO read pointer with empty/almost-empty/level
//
// Ports:
//   i_rd_clk  read-domain clock, all state changes on its rising edge
//   i_rst     asynchronous active-high reset
//   bus       rdptr_empty_ae_if.slave (read request, synchronised Gray write
//             pointer, underflow clear in; Gray read pointer, RAM address,
//             empty, almost-empty, level and sticky underflow out)
// Parameters:
//   PTR_WIDTH      address width; depth is 2**PTR_WIDTH, pointers carry one
//                  extra wrap bit
//   AEMPTY_THRESH  almost-empty threshold in entries, 0 .. 2**PTR_WIDTH
module rdptr_empty_ae #(
   parameter int PTR_WIDTH     = 3,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic           i_rd_clk,
   input  logic           i_rst,
   rdptr_empty_ae_if.slave bus
);

   localparam int PW = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] AE_THRESH = PW'(AEMPTY_THRESH);

   logic [PTR_WIDTH:0] rbin;
   logic [PTR_WIDTH:0] rbin_next;
   logic [PTR_WIDTH:0] rgray_next;
   logic [PTR_WIDTH:0] wbin;
   logic [PTR_WIDTH:0] level_next;
   logic               rd_inc;

   logic [PTR_WIDTH:0] rgray_q;
   logic               empty_q;
   logic               aempty_q;
   logic [PTR_WIDTH:0] level_q;
   logic               uf_q;

   // A read only advances the pointer when the registered flag says data is
   // present; the flag is pessimistic, so this never overtakes the writer.
   always_comb begin
      rd_inc     = bus.i_rd_en & ~empty_q;
      rbin_next  = rbin + {{PTR_WIDTH{1'b0}}, rd_inc};
      rgray_next = rbin_next ^ (rbin_next >> 1);
   end

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      wbin = '0;
      for (int k = 0; k <= PTR_WIDTH; k++) begin
         wbin[k] = ^(bus.i_wrptr_gray_sync >> k);
      end
   end

   // Level uses the post-read pointer so a read and a write in the same cycle
   // cancel out, and the last read shows empty on the very next edge.
   always_comb begin
      level_next = wbin - rbin_next;
   end

   always_ff @(posedge i_rd_clk or posedge i_rst) begin
      if (i_rst) begin
         rbin     <= '0;
         rgray_q  <= '0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         level_q  <= '0;
         uf_q     <= 1'b0;
      end else begin
         rbin     <= rbin_next;
         rgray_q  <= rgray_next;
         // Comparing in the Gray domain avoids depending on the decoder for
         // the most timing-critical flag.
         empty_q  <= (rgray_next == bus.i_wrptr_gray_sync);
         aempty_q <= (level_next <= AE_THRESH);
         level_q  <= level_next;
         // Set has priority over clear so a same-cycle event is never lost.
         if (bus.i_rd_en && empty_q) begin
            uf_q <= 1'b1;
         end else if (bus.i_uf_clr) begin
            uf_q <= 1'b0;
         end
      end
   end

   assign bus.o_rdptr_gray = rgray_q;
   assign bus.o_rdaddr     = rbin[PTR_WIDTH-1:0];
   assign bus.o_empty      = empty_q;
   assign bus.o_aempty     = aempty_q;
   assign bus.o_rd_level   = level_q;
   assign bus.o_underflow  = uf_q;

endmodule

// File: tb/tb_rdptr_empty_ae.sv
// tb/tb_rdptr_empty_ae.sv - self-checking bench for rdptr_empty_ae
module tb_rdptr_empty_ae;

   logic clk;
   logic rst;

   rdptr_empty_ae_if #(.PTR_WIDTH(3)) bus ();

   rdptr_empty_ae #(
      .PTR_WIDTH(3),
      .AEMPTY_THRESH(2)
   ) dut (
      .i_rd_clk(clk),
      .i_rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: absolute entry counts, flags derived from their difference.
   int m_rd;
   int m_wr;
   int m_level;
   bit m_empty;
   bit m_uf;

   function automatic logic [3:0] gray4(input int b);
      logic [3:0] x;
      x = 4'(b % 16);
      return x ^ (x >> 1);
   endfunction

   task automatic model_reset();
      m_rd = 0; m_wr = 0; m_level = 0; m_empty = 1'b1; m_uf = 1'b0;
   endtask

   task automatic step(input bit rd, input bit clr);
      bus.i_rd_en = rd;
      bus.i_uf_clr = clr;
      bus.i_wrptr_gray_sync = gray4(m_wr);
      @(posedge clk);
      if (rd && m_empty) m_uf = 1'b1;
      else if (clr) m_uf = 1'b0;
      if (rd && !m_empty) m_rd++;
      m_level = m_wr - m_rd;
      m_empty = (m_level == 0);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_rd_en = 1'b0;
      bus.i_uf_clr = 1'b0;
      bus.i_wrptr_gray_sync = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_rd_en = 1'b1;
      bus.i_uf_clr = 1'b0;
      bus.i_wrptr_gray_sync = 4'b0111;
      model_reset();
      #1;
      n_tests++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.o_empty); end
      n_tests++; if (bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", bus.o_aempty); end
      n_tests++; if (bus.o_rd_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.o_rd_level); end
      n_tests++; if (bus.o_rdptr_gray !== 4'd0) begin n_fail++; $display("FAIL reset_gray: got %b expected 0000", bus.o_rdptr_gray); end
      n_tests++; if (bus.o_rdaddr !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.o_rdaddr); end
      n_tests++; if (bus.o_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf: got %b expected 0", bus.o_underflow); end
      // Reads during reset are ignored even across edges.
      @(posedge clk);
      #1;
      n_tests++; if (bus.o_rdaddr !== 3'd0) begin n_fail++; $display("FAIL reset_rd_ignored: got %0d expected 0", bus.o_rdaddr); end
      do_reset();
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b1, 1'b0);
      n_tests++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL uf_empty: got %b expected 1", bus.o_empty); end
      n_tests++; if (bus.o_rdptr_gray !== 4'd0) begin n_fail++; $display("FAIL uf_gray: got %b expected 0000", bus.o_rdptr_gray); end
      n_tests++; if (bus.o_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b expected 1", bus.o_underflow); end
      step(1'b0, 1'b0);
      n_tests++; if (bus.o_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", bus.o_underflow); end
      step(1'b0, 1'b1);
      n_tests++; if (bus.o_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b expected 0", bus.o_underflow); end
   endtask

   task automatic test_uf_set_wins();
      do_reset();
      step(1'b1, 1'b1);
      n_tests++; if (bus.o_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set_wins: got %b expected 1", bus.o_underflow); end
   endtask

   task automatic test_level_drain();
      do_reset();
      m_wr = 5;
      step(1'b0, 1'b0);
      n_tests++; if (bus.o_rd_level !== 4'd5) begin n_fail++; $display("FAIL drain_level5: got %0d expected 5", bus.o_rd_level); end
      n_tests++; if (bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL drain_empty5: got %b expected 0", bus.o_empty); end
      n_tests++; if (bus.o_aempty !== 1'b0) begin n_fail++; $display("FAIL drain_aempty5: got %b expected 0", bus.o_aempty); end
      repeat (3) step(1'b1, 1'b0);
      n_tests++; if (bus.o_rd_level !== 4'd2) begin n_fail++; $display("FAIL drain_level2: got %0d expected 2", bus.o_rd_level); end
      n_tests++; if (bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL drain_aempty2: got %b expected 1", bus.o_aempty); end
      n_tests++; if (bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL drain_empty2: got %b expected 0", bus.o_empty); end
      repeat (2) step(1'b1, 1'b0);
      n_tests++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty0: got %b expected 1", bus.o_empty); end
      n_tests++; if (bus.o_rdaddr !== 3'd5) begin n_fail++; $display("FAIL drain_addr5: got %0d expected 5", bus.o_rdaddr); end
      repeat (2) step(1'b1, 1'b0);
      n_tests++; if (bus.o_rdaddr !== 3'd5) begin n_fail++; $display("FAIL drain_no_move: got %0d expected 5", bus.o_rdaddr); end
      n_tests++; if (bus.o_underflow !== 1'b1) begin n_fail++; $display("FAIL drain_uf: got %b expected 1", bus.o_underflow); end
   endtask

   task automatic test_wrap();
      do_reset();
      m_wr = 8;
      step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      m_wr = 16;
      step(1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b0);
      n_tests++; if (bus.o_rdptr_gray !== 4'b1000) begin n_fail++; $display("FAIL wrap_pre_gray: got %b expected 1000", bus.o_rdptr_gray); end
      n_tests++; if (bus.o_rd_level !== 4'd1) begin n_fail++; $display("FAIL wrap_pre_level: got %0d expected 1", bus.o_rd_level); end
      step(1'b1, 1'b0);
      n_tests++; if (bus.o_rdptr_gray !== 4'b0000) begin n_fail++; $display("FAIL wrap_gray: got %b expected 0000", bus.o_rdptr_gray); end
      n_tests++; if (bus.o_rdaddr !== 3'd0) begin n_fail++; $display("FAIL wrap_addr: got %0d expected 0", bus.o_rdaddr); end
      n_tests++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", bus.o_empty); end
      n_tests++; if (bus.o_rd_level !== 4'd0) begin n_fail++; $display("FAIL wrap_level: got %0d expected 0", bus.o_rd_level); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] g_before;
      do_reset();
      m_wr = 3;
      step(1'b0, 1'b0);
      g_before = bus.o_rdptr_gray;
      m_wr = 4;
      step(1'b1, 1'b0);
      n_tests++; if (bus.o_rd_level !== 4'd3) begin n_fail++; $display("FAIL b2b_level: got %0d expected 3", bus.o_rd_level); end
      n_tests++; if ($countones(bus.o_rdptr_gray ^ g_before) != 1) begin n_fail++; $display("FAIL b2b_gray_1bit: got %b from %b expected one-bit change", bus.o_rdptr_gray, g_before); end
      n_tests++; if (bus.o_rdptr_gray !== gray4(1)) begin n_fail++; $display("FAIL b2b_gray: got %b expected %b", bus.o_rdptr_gray, gray4(1)); end
   endtask

   task automatic test_async_reset();
      do_reset();
      m_wr = 8;
      step(1'b0, 1'b0);
      repeat (6) step(1'b1, 1'b0);
      n_tests++; if (bus.o_rdaddr !== 3'd6) begin n_fail++; $display("FAIL areset_pre_addr: got %0d expected 6", bus.o_rdaddr); end
      bus.i_rd_en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      n_tests++; if (bus.o_rdaddr !== 3'd0) begin n_fail++; $display("FAIL areset_addr: got %0d expected 0", bus.o_rdaddr); end
      n_tests++; if (bus.o_rdptr_gray !== 4'd0) begin n_fail++; $display("FAIL areset_gray: got %b expected 0000", bus.o_rdptr_gray); end
      n_tests++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL areset_empty: got %b expected 1", bus.o_empty); end
      n_tests++; if (bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL areset_aempty: got %b expected 1", bus.o_aempty); end
      n_tests++; if (bus.o_rd_level !== 4'd0) begin n_fail++; $display("FAIL areset_level: got %0d expected 0", bus.o_rd_level); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      m_wr = 2;
      step(1'b0, 1'b0);
      n_tests++; if (bus.o_rd_level !== 4'd2) begin n_fail++; $display("FAIL areset_level2: got %0d expected 2", bus.o_rd_level); end
      n_tests++; if (bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL areset_aempty2: got %b expected 1", bus.o_aempty); end
      n_tests++; if (bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL areset_empty2: got %b expected 0", bus.o_empty); end
   endtask

   task automatic test_random();
      bit rd;
      bit clr;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rd  = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 7) == 0);
         if ((m_wr - m_rd) < 8 && $urandom_range(0, 1) == 1) m_wr++;
         step(rd, clr);
         n_tests++; if (bus.o_rd_level !== 4'(m_level)) begin n_fail++; $display("FAIL rand_level @%0d: got %0d expected %0d", i, bus.o_rd_level, m_level); end
         n_tests++; if (bus.o_empty !== m_empty) begin n_fail++; $display("FAIL rand_empty @%0d: got %b expected %b", i, bus.o_empty, m_empty); end
         n_tests++; if (bus.o_aempty !== (m_level <= 2)) begin n_fail++; $display("FAIL rand_aempty @%0d: got %b expected %b", i, bus.o_aempty, (m_level <= 2)); end
         n_tests++; if (bus.o_rdptr_gray !== gray4(m_rd)) begin n_fail++; $display("FAIL rand_gray @%0d: got %b expected %b", i, bus.o_rdptr_gray, gray4(m_rd)); end
         n_tests++; if (bus.o_rdaddr !== 3'(m_rd % 8)) begin n_fail++; $display("FAIL rand_addr @%0d: got %0d expected %0d", i, bus.o_rdaddr, m_rd % 8); end
         n_tests++; if (bus.o_underflow !== m_uf) begin n_fail++; $display("FAIL rand_uf @%0d: got %b expected %b", i, bus.o_underflow, m_uf); end
      end
   endtask

   initial begin
      test_reset();
      test_underflow();
      test_uf_set_wins();
      test_level_drain();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rdptr_empty_ae.md
RDPTR_EMPTY_AE -- requirements
Module: rdptr_empty_ae

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 3, meaning address width; FIFO depth is 2**PTR_WIDTH and pointers are PTR_WIDTH+1 bits.
REQ-002 The block SHALL have parameter AEMPTY_THRESH, default 2, meaning almost-empty threshold in entries; legal range 0 to 2**PTR_WIDTH.
REQ-003 i_rd_clk  input  1  read-domain clock; the block has one clock, and all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_rd_en  input  1  read request.
REQ-006 i_wrptr_gray_sync  input  PTR_WIDTH+1  write pointer, Gray-coded, already synchronised into the read domain.
REQ-007 i_uf_clr  input  1  clears the sticky underflow flag.
REQ-008 o_rdptr_gray  output  PTR_WIDTH+1  registered Gray read pointer, for synchronisation into the write domain.
REQ-009 o_rdaddr  output  PTR_WIDTH  RAM read address.
REQ-010 o_empty  output  1  registered empty flag.
REQ-011 o_aempty  output  1  registered almost-empty flag.
REQ-012 o_rd_level  output  PTR_WIDTH+1  registered occupancy seen by the read side.
REQ-013 o_underflow  output  1  sticky flag for a read attempted while empty.

Function
REQ-014 Internal binary pointer rbin (PTR_WIDTH+1 bits); rd_inc = i_rd_en AND NOT o_empty.
REQ-015 rbin_next = rbin + rd_inc, modulo 2**(PTR_WIDTH+1); wraps from all-ones to 0 with no special case.
REQ-016 rgray_next = rbin_next XOR (rbin_next >> 1); o_rdptr_gray <= rgray_next each cycle, so it equals Gray(rbin) and is glitch-free (one register, one bit change per increment).
REQ-017 o_rdaddr = rbin[PTR_WIDTH-1:0], combinational from the register, valid in the same cycle the pointer updates.
REQ-018 wbin = Gray-to-binary of i_wrptr_gray_sync (bit MSB passes through; bit k = XOR of bits MSB..k), combinational.
REQ-019 o_empty <= (rgray_next == i_wrptr_gray_sync); a read that consumes the last entry asserts o_empty on the next edge, with 0 cycles of extra latency.
REQ-020 level_next = wbin - rbin_next, modulo 2**(PTR_WIDTH+1); o_rd_level <= level_next.
REQ-021 o_aempty <= (level_next <= AEMPTY_THRESH); o_aempty is always 1 whenever o_empty is 1.
REQ-022 o_empty, o_aempty and o_rd_level deassert or increase only after a write-pointer change reaches i_wrptr_gray_sync; they are pessimistic by the synchroniser latency.
REQ-023 Read while empty (i_rd_en=1, o_empty=1): the pointer does not move, and o_underflow <= 1 on that edge.
REQ-024 o_underflow stays set until i_uf_clr=1; if a set and a clear occur in the same cycle, the set wins.
REQ-025 Simultaneous read and write-pointer advance: level_next reflects both; with one read and one write, level is unchanged.
REQ-026 Values of i_wrptr_gray_sync that imply a level greater than 2**PTR_WIDTH are outside the contract; outputs follow the modular arithmetic above and no checking is done.

Reset
REQ-027 While i_rst=1, independent of the clock: rbin=0, o_rdptr_gray=0, o_rdaddr=0, o_empty=1, o_aempty=1, o_rd_level=0, o_underflow=0.
REQ-028 Reset asserted mid-operation aborts any read immediately; the first rising edge after deassertion evaluates REQ-019 to REQ-021 normally from pointer 0.
REQ-029 i_rd_en is ignored while i_rst=1.

Verification (PTR_WIDTH=3, AEMPTY_THRESH=2)
REQ-030 Reset, then drive i_wrptr_gray_sync=0 and i_rd_en=1 -> o_empty=1, o_rdptr_gray=0, o_underflow=1 after the first edge; then i_uf_clr=1 for one cycle -> o_underflow=0.
REQ-031 Drive i_wrptr_gray_sync=Gray(5)=0111, no reads -> after one edge, o_rd_level=5, o_empty=0, o_aempty=0; read 3 times -> o_rd_level=2, o_aempty=1, o_empty=0; read 2 more times -> o_empty=1, o_rdaddr=5, and further reads do not move the pointer.
REQ-032 Wrap: preload by reading to rbin=15 with i_wrptr_gray_sync=Gray(0)=0000 and one entry available; read once -> rbin=0, o_rdptr_gray=0000 (from 1000), o_empty=1, o_rd_level=0.
REQ-033 Read and wptr advance in the same cycle at level 3 -> o_rd_level stays 3, and o_rdptr_gray changes by exactly one bit.
REQ-034 Assert i_rst mid-burst with rbin=6 -> all outputs equal their REQ-027 values without waiting for a clock edge; after release, i_wrptr_gray_sync=Gray(2) -> o_rd_level=2, o_aempty=1, o_empty=0.
REQ-035 i_rd_en=1 while empty and i_uf_clr=1 in the same cycle -> o_underflow=1 (set wins).
